plic_gateway_arb: RTL and testbench

- PLIC core logic for target 0. It sits next to the interrupt register file.
- Per-source gateways turn external interrupt levels into one-shot pending requests, driven out as plic_reg_gate.
- It consumes the ip/ie/priority/threshold state from the register file and runs a pipelined priority arbitration.
- Results: final_id, which the register file latches on claim, and meip to the core.

---
 rtl/plic_pkg.sv | 17 +
 rtl/plic_gateway.sv | 61 ++++++
 rtl/plic_gateway_arb.sv | 136 +++++++++++++
 tb/tb_plic_gateway_arb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// Shared types and sizing helpers for the PLIC target-0 gateway/arbiter slice.
package plic_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    INFLIGHT = 2'd2
  } gw_state_e;

  localparam int ARB_GROUP = 8;

  // Sources 0..ext_irq_num split into groups of ARB_GROUP, last group padded.
  function automatic int grp_count(input int ext_irq_num);
    return (ext_irq_num + ARB_GROUP) / ARB_GROUP;
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: 2-flop synchroniser plus one-shot request FSM.
//   state    | meaning
//   IDLE     | no request outstanding, next synchronised high level raises gate
//   PEND     | gate issued, waiting for the target to claim this source
//   INFLIGHT | claimed, waiting for the completion write
module plic_gateway
  import plic_pkg::*;
#(
  parameter int SRC_ID = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ext_irq,
  input  logic [7:0] claim_id,
  input  logic [7:0] cmplt_id,
  input  logic       cmplt_vld,
  output logic       gate
);

  localparam logic [7:0] MY_ID = 8'(SRC_ID);

  logic      sync1;
  logic      irq_s;
  gw_state_e state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      irq_s <= 1'b0;
    end else begin
      sync1 <= ext_irq;
      irq_s <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gate  <= 1'b0;
    end else begin
      gate <= 1'b0;
      case (state)
        IDLE: begin
          if (irq_s) begin
            gate  <= 1'b1;
            state <= PEND;
          end
        end
        // A complete arriving while still pending is dropped on purpose.
        PEND: begin
          if (claim_id == MY_ID) state <= INFLIGHT;
        end
        INFLIGHT: begin
          if (cmplt_vld && (cmplt_id == MY_ID)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/plic_gateway_arb.sv
// PLIC target-0 core: per-source gateways and a two-stage priority arbiter
// producing the claimable id and meip.
module plic_gateway_arb
  import plic_pkg::*;
#(
  parameter int EXT_IRQ_NUM = 31,
  parameter int PRIO_WIDTH  = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [EXT_IRQ_NUM:0]                   ext_irq,
  input  logic [EXT_IRQ_NUM:0]                   ip_r,
  input  logic [EXT_IRQ_NUM:0]                   ie_r,
  input  logic [PRIO_WIDTH*(EXT_IRQ_NUM+1)-1:0]  prio_r_1d,
  input  logic [PRIO_WIDTH-1:0]                  threshold_r,
  input  logic [7:0]                             claim_id,
  input  logic [7:0]                             cmplt_id,
  input  logic                                   cmplt_vld,
  output logic [EXT_IRQ_NUM:0]                   plic_reg_gate,
  output logic [7:0]                             final_id,
  output logic                                   meip
);

  localparam int NUM_SRC = EXT_IRQ_NUM + 1;
  localparam int NUM_GRP = grp_count(EXT_IRQ_NUM);
  localparam int PAD_SRC = NUM_GRP * ARB_GROUP;

  // Source 0 is reserved and never interrupts.
  logic unused_src0;
  assign unused_src0      = ext_irq[0] | ip_r[0] | ie_r[0] | (|prio_r_1d[PRIO_WIDTH-1:0]);
  assign plic_reg_gate[0] = 1'b0;

  for (genvar i = 1; i < NUM_SRC; i++) begin : g_gw
    plic_gateway #(
      .SRC_ID (i)
    ) u_gw (
      .clk       (clk),
      .rst       (rst),
      .ext_irq   (ext_irq[i]),
      .claim_id  (claim_id),
      .cmplt_id  (cmplt_id),
      .cmplt_vld (cmplt_vld),
      .gate      (plic_reg_gate[i])
    );
  end

  logic [PAD_SRC-1:0]    elig;
  logic [PRIO_WIDTH-1:0] prio [PAD_SRC];

  always_comb begin
    elig = '0;
    for (int i = 0; i < PAD_SRC; i++) prio[i] = '0;
    for (int i = 1; i < NUM_SRC; i++) begin
      prio[i] = prio_r_1d[i*PRIO_WIDTH +: PRIO_WIDTH];
      elig[i] = ip_r[i] & ie_r[i] & (prio[i] != '0) & (prio[i] > threshold_r);
    end
  end

  // Stage 1: per-group winner; strict compare in ascending id order keeps the lowest id on ties.
  logic                  grp_v  [NUM_GRP];
  logic [PRIO_WIDTH-1:0] grp_p  [NUM_GRP];
  logic [7:0]            grp_id [NUM_GRP];

  always_comb begin
    for (int g = 0; g < NUM_GRP; g++) begin
      grp_v[g]  = 1'b0;
      grp_p[g]  = '0;
      grp_id[g] = '0;
      for (int k = 0; k < ARB_GROUP; k++) begin
        if (elig[g*ARB_GROUP+k] && (!grp_v[g] || (prio[g*ARB_GROUP+k] > grp_p[g]))) begin
          grp_v[g]  = 1'b1;
          grp_p[g]  = prio[g*ARB_GROUP+k];
          grp_id[g] = 8'(g*ARB_GROUP+k);
        end
      end
    end
  end

  logic                  s1_v  [NUM_GRP];
  logic [PRIO_WIDTH-1:0] s1_p  [NUM_GRP];
  logic [7:0]            s1_id [NUM_GRP];

  // A claim flushes both stages so the just-claimed id is never presented twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < NUM_GRP; g++) begin
        s1_v[g]  <= 1'b0;
        s1_p[g]  <= '0;
        s1_id[g] <= '0;
      end
    end else if (claim_id != 8'd0) begin
      for (int g = 0; g < NUM_GRP; g++) begin
        s1_v[g]  <= 1'b0;
        s1_p[g]  <= '0;
        s1_id[g] <= '0;
      end
    end else begin
      for (int g = 0; g < NUM_GRP; g++) begin
        s1_v[g]  <= grp_v[g];
        s1_p[g]  <= grp_p[g];
        s1_id[g] <= grp_id[g];
      end
    end
  end

  logic                  win_v;
  logic [PRIO_WIDTH-1:0] win_p;
  logic [7:0]            win_id;

  always_comb begin
    win_v  = 1'b0;
    win_p  = '0;
    win_id = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      if (s1_v[g] && (!win_v || (s1_p[g] > win_p))) begin
        win_v  = 1'b1;
        win_p  = s1_p[g];
        win_id = s1_id[g];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      final_id <= 8'd0;
      meip     <= 1'b0;
    end else if (claim_id != 8'd0) begin
      final_id <= 8'd0;
      meip     <= 1'b0;
    end else begin
      final_id <= win_v ? win_id : 8'd0;
      meip     <= win_v;
    end
  end

endmodule

// File: tb/tb_plic_gateway_arb.sv
// Scoreboard bench for plic_gateway_arb: stimulus pushes timed expectations,
// a negedge monitor pops and compares them.
module tb_plic_gateway_arb;

  localparam int N  = 31;
  localparam int PW = 3;

  localparam int K_GATE = 0;
  localparam int K_ID   = 1;
  localparam int K_MEIP = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N:0]        ext_irq;
  logic [N:0]        ip_r;
  logic [N:0]        ie_r;
  logic [PW*(N+1)-1:0] prio_r_1d;
  logic [PW-1:0]     threshold_r;
  logic [7:0]        claim_id;
  logic [7:0]        cmplt_id;
  logic              cmplt_vld;
  logic [N:0]        plic_reg_gate;
  logic [7:0]        final_id;
  logic              meip;

  plic_gateway_arb #(
    .EXT_IRQ_NUM (N),
    .PRIO_WIDTH  (PW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ext_irq       (ext_irq),
    .ip_r          (ip_r),
    .ie_r          (ie_r),
    .prio_r_1d     (prio_r_1d),
    .threshold_r   (threshold_r),
    .claim_id      (claim_id),
    .cmplt_id      (cmplt_id),
    .cmplt_vld     (cmplt_vld),
    .plic_reg_gate (plic_reg_gate),
    .final_id      (final_id),
    .meip          (meip)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int due, input int kind, input logic [31:0] val, input string tag);
    exp_t e;
    e.due  = due;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    int          j;
    logic [31:0] obs;
    j = 0;
    while (j < sb.size()) begin
      if (sb[j].due <= cyc) begin
        if (sb[j].due < cyc) chk({sb[j].tag, "_late"}, 32'(cyc), 32'(sb[j].due));
        else begin
          case (sb[j].kind)
            K_GATE:  obs = plic_reg_gate;
            K_ID:    obs = {24'd0, final_id};
            default: obs = {31'd0, meip};
          endcase
          chk(sb[j].tag, obs, sb[j].val);
        end
        sb.delete(j);
      end else begin
        j++;
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic set_prio(input int i, input logic [PW-1:0] p);
    prio_r_1d[i*PW +: PW] = p;
  endtask

  task automatic pulse_cmplt(input logic [7:0] id);
    cmplt_vld = 1'b1;
    cmplt_id  = id;
    step(1);
    cmplt_vld = 1'b0;
    cmplt_id  = 8'd0;
  endtask

  int t;
  logic [7:0] ign_ids [3];

  initial begin
    rst = 1'b1; ext_irq = '0; ip_r = '0; ie_r = '0; prio_r_1d = '0;
    threshold_r = '0; claim_id = '0; cmplt_id = '0; cmplt_vld = 1'b0;
    ign_ids[0] = 8'd4; ign_ids[1] = 8'd0; ign_ids[2] = 8'd37;
    step(3);
    chk("rst_id", {24'd0, final_id}, 32'd0);
    chk("rst_meip", {31'd0, meip}, 32'd0);
    chk("rst_gate", plic_reg_gate, 32'd0);
    rst = 1'b0;
    step(2);

    // source 0 never gates
    t = cyc; ext_irq[0] = 1'b1;
    for (int k = 1; k <= 5; k++) push(t + k, K_GATE, 32'd0, "src0_gate");
    step(6); ext_irq[0] = 1'b0;

    // single source 5
    set_prio(5, 3'd3); threshold_r = '0; ie_r[5] = 1'b1;
    t = cyc; ext_irq[5] = 1'b1;
    push(t + 2, K_GATE, 32'd0, "s5_gate_early");
    push(t + 3, K_GATE, 32'h20, "s5_gate");
    push(t + 4, K_GATE, 32'd0, "s5_gate_once");
    push(t + 5, K_GATE, 32'd0, "s5_gate_hold");
    push(t + 5, K_ID, 32'd0, "s5_id_early");
    step(4); ip_r[5] = 1'b1;
    push(t + 6, K_ID, 32'd5, "s5_id");
    push(t + 6, K_MEIP, 32'd1, "s5_meip");
    step(3);

    // async reset mid-traffic, gateway 5 pending, level still high
    rst = 1'b1;
    #1;
    chk("rstmid_id", {24'd0, final_id}, 32'd0);
    chk("rstmid_meip", {31'd0, meip}, 32'd0);
    chk("rstmid_gate", plic_reg_gate, 32'd0);
    ip_r = '0;
    step(2); rst = 1'b0;
    t = cyc;
    push(t + 2, K_GATE, 32'd0, "rel_gate_early");
    push(t + 3, K_GATE, 32'h20, "rel_gate_idle");
    push(t + 4, K_GATE, 32'd0, "rel_gate_once");
    step(4); ip_r[5] = 1'b1;
    push(t + 6, K_ID, 32'd5, "rel_id");
    step(3);

    // claim 5: flush and no re-gate while in flight
    t = cyc; claim_id = 8'd5; ip_r[5] = 1'b0;
    push(t + 1, K_ID, 32'd0, "claim_flush_id");
    push(t + 1, K_MEIP, 32'd0, "claim_flush_meip");
    push(t + 3, K_ID, 32'd0, "claim_id_after");
    for (int k = 1; k <= 4; k++) push(t + k, K_GATE, 32'd0, "claim_nogate");
    step(1); claim_id = 8'd0; step(3);

    // completes for other/illegal ids are ignored
    foreach (ign_ids[n]) begin
      t = cyc;
      for (int k = 1; k <= 3; k++) push(t + k, K_GATE, 32'd0, "cmplt_ignored");
      pulse_cmplt(ign_ids[n]);
      step(3);
    end

    // complete 5: re-gate one cycle after returning to IDLE
    t = cyc;
    push(t + 1, K_GATE, 32'd0, "cmplt5_gate_early");
    push(t + 2, K_GATE, 32'h20, "cmplt5_regate");
    push(t + 3, K_GATE, 32'd0, "cmplt5_gate_once");
    pulse_cmplt(8'd5);
    step(3);

    // simultaneous claim and complete from PEND: ends INFLIGHT
    t = cyc; claim_id = 8'd5; cmplt_vld = 1'b1; cmplt_id = 8'd5;
    for (int k = 1; k <= 4; k++) push(t + k, K_GATE, 32'd0, "simul_nogate");
    step(1); claim_id = 8'd0; cmplt_vld = 1'b0; cmplt_id = 8'd0;
    step(4);
    t = cyc;
    push(t + 2, K_GATE, 32'h20, "simul_regate");
    pulse_cmplt(8'd5);
    step(3);
    ext_irq[5] = 1'b0;

    // tie-break
    ip_r = '0; ie_r = '0; prio_r_1d = '0; threshold_r = '0;
    t = cyc;
    ip_r[3] = 1'b1; ip_r[9] = 1'b1; ip_r[12] = 1'b1; ip_r[20] = 1'b1;
    ie_r = ip_r;
    set_prio(3, 3'd2); set_prio(9, 3'd2); set_prio(12, 3'd1); set_prio(20, 3'd1);
    push(t + 2, K_ID, 32'd3, "tie_id");
    push(t + 2, K_MEIP, 32'd1, "tie_meip");
    step(3);
    t = cyc; set_prio(20, 3'd4);
    push(t + 1, K_ID, 32'd3, "prio20_latency");
    push(t + 2, K_ID, 32'd20, "prio20_id");
    step(3);

    // claim flush with a live winner
    t = cyc; claim_id = 8'd9;
    push(t + 1, K_ID, 32'd0, "flush_id");
    push(t + 1, K_MEIP, 32'd0, "flush_meip");
    push(t + 2, K_ID, 32'd0, "flush_hold");
    push(t + 3, K_ID, 32'd20, "flush_return");
    push(t + 3, K_MEIP, 32'd1, "flush_return_meip");
    step(1); claim_id = 8'd0; step(3);

    // threshold and zero priority
    t = cyc; ip_r = '0; ie_r = '0; ip_r[7] = 1'b1; ie_r[7] = 1'b1;
    set_prio(7, 3'd2); threshold_r = 3'd2;
    push(t + 2, K_ID, 32'd0, "thr_eq_id");
    push(t + 2, K_MEIP, 32'd0, "thr_eq_meip");
    step(3);
    t = cyc; threshold_r = 3'd1;
    push(t + 2, K_ID, 32'd7, "thr_lt_id");
    push(t + 2, K_MEIP, 32'd1, "thr_lt_meip");
    step(3);
    t = cyc; set_prio(7, 3'd0); threshold_r = 3'd0;
    push(t + 2, K_ID, 32'd0, "prio0_id");
    push(t + 2, K_MEIP, 32'd0, "prio0_meip");
    step(3);
    t = cyc; set_prio(7, 3'd5); ie_r = '0;
    push(t + 2, K_ID, 32'd0, "ie_off_id");
    step(3);
    t = cyc; ie_r[7] = 1'b1;
    push(t + 2, K_ID, 32'd7, "ie_on_id");
    step(3);

    for (int k = 0; k < 20 && sb.size() > 0; k++) step(1);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
